// File: rtl/btn_debounce_repeat_if.sv
// Button conditioning signal bundle: raw button in, debounced level/pulse/held out.
// master = conditioning block, slave = consumer that owns the raw pin side.
interface btn_debounce_repeat_if;
  logic btn;
  logic btn_pulse;
  logic btn_level;
  logic btn_held;

  modport master (
    input  btn,
    output btn_pulse,
    output btn_level,
    output btn_held
  );

  modport slave (
    output btn,
    input  btn_pulse,
    input  btn_level,
    input  btn_held
  );
endinterface

// File: rtl/btn_debounce_repeat.sv
// Push-button synchroniser, stable-time debouncer and press-pulse generator.
// Define BTN_AUTOREPEAT_EN to build the auto-repeat (REPEATING state, rp_cnt).
module btn_debounce_repeat #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned REPEAT_DELAY    = 12500000,
  parameter int unsigned REPEAT_PERIOD   = 2500000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  btn_debounce_repeat_if.master bus
);

  // Both counters are 24 bits wide; out-of-range parameters stop elaboration.
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES >= (1 << 24)) begin : g_bad_debounce
    $error("btn_debounce_repeat: DEBOUNCE_CYCLES out of range 1..2^24-1");
  end
  if (REPEAT_DELAY < 1 || REPEAT_DELAY >= (1 << 24)) begin : g_bad_delay
    $error("btn_debounce_repeat: REPEAT_DELAY out of range 1..2^24-1");
  end
  if (REPEAT_PERIOD < 1 || REPEAT_PERIOD >= (1 << 24)) begin : g_bad_period
    $error("btn_debounce_repeat: REPEAT_PERIOD out of range 1..2^24-1");
  end

  localparam logic [23:0] DB_LAST = 24'(DEBOUNCE_CYCLES - 1);

  logic        btn_s0;
  logic        btn_s1;
  logic        level;
  logic [23:0] db_cnt;
  logic        toggle;
  logic        rise;
  logic        fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s0 <= 1'b0;
      btn_s1 <= 1'b0;
    end else begin
      btn_s0 <= bus.btn;
      btn_s1 <= btn_s0;
    end
  end

  // rise/fall mark the edge on which level flips, so the FSM reacts on that same edge.
  assign toggle = (btn_s1 != level) && (db_cnt == DB_LAST);
  assign rise   = toggle && !level;
  assign fall   = toggle && level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level  <= 1'b0;
      db_cnt <= '0;
    end else if (toggle) begin
      level  <= ~level;
      db_cnt <= '0;
    end else if (btn_s1 == level) begin
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 24'd1;
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  typedef enum logic [1:0] {RELEASED, PRESSED, REPEATING} state_t;

  localparam logic [23:0] RP_DELAY_LAST  = 24'(REPEAT_DELAY - 1);
  localparam logic [23:0] RP_PERIOD_LAST = 24'(REPEAT_PERIOD - 1);

  state_t      state;
  state_t      state_nxt;
  logic [23:0] rp_cnt;
  logic [23:0] rp_nxt;
  logic        pulse;
  logic        pulse_nxt;
  logic        held;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RELEASED;
      rp_cnt <= '0;
      pulse  <= 1'b0;
      held   <= 1'b0;
    end else begin
      state  <= state_nxt;
      rp_cnt <= rp_nxt;
      pulse  <= pulse_nxt;
      held   <= (state_nxt == REPEATING);
    end
  end

  // A release always wins over a timer expiry on the same edge.
  always_comb begin
    state_nxt = state;
    rp_nxt    = rp_cnt;
    pulse_nxt = 1'b0;
    case (state)
      RELEASED: begin
        rp_nxt = '0;
        if (rise) begin
          state_nxt = PRESSED;
          pulse_nxt = 1'b1;
        end
      end
      PRESSED: begin
        if (fall) begin
          state_nxt = RELEASED;
          rp_nxt    = '0;
        end else if (rp_cnt == RP_DELAY_LAST) begin
          state_nxt = REPEATING;
          pulse_nxt = 1'b1;
          rp_nxt    = '0;
        end else begin
          rp_nxt = rp_cnt + 24'd1;
        end
      end
      REPEATING: begin
        if (fall) begin
          state_nxt = RELEASED;
          rp_nxt    = '0;
        end else if (rp_cnt == RP_PERIOD_LAST) begin
          pulse_nxt = 1'b1;
          rp_nxt    = '0;
        end else begin
          rp_nxt = rp_cnt + 24'd1;
        end
      end
      default: begin
        state_nxt = RELEASED;
        rp_nxt    = '0;
      end
    endcase
  end

  assign bus.btn_held = held;
`else
  typedef enum logic {RELEASED, PRESSED} state_t;

  state_t state;
  state_t state_nxt;
  logic   pulse;
  logic   pulse_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RELEASED;
      pulse <= 1'b0;
    end else begin
      state <= state_nxt;
      pulse <= pulse_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pulse_nxt = 1'b0;
    case (state)
      RELEASED: begin
        if (rise) begin
          state_nxt = PRESSED;
          pulse_nxt = 1'b1;
        end
      end
      PRESSED: begin
        if (fall) state_nxt = RELEASED;
      end
    endcase
  end

  assign bus.btn_held = 1'b0;
`endif

  assign bus.btn_pulse = pulse;
  assign bus.btn_level = level;

endmodule

// File: tb/tb_btn_debounce_repeat.sv
// Directed bench for btn_debounce_repeat (DEBOUNCE=4, DELAY=20, PERIOD=8).
// Auto-repeat checks run when BTN_AUTOREPEAT_EN is defined, single-pulse checks otherwise.
module tb_btn_debounce_repeat;
  localparam int DB  = 4;
  localparam int RD  = 20;
  localparam int RP  = 8;
  localparam int LAT = DB + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_total = 0;
  int   n_pass  = 0;

  btn_debounce_repeat_if bus ();

  btn_debounce_repeat #(
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Button already driven high; pulse and level must appear on edge LAT exactly.
  task automatic expect_press(input string tag);
    int early = 0;
    for (int k = 1; k <= LAT; k++) begin
      tick();
      if (k < LAT) early += int'(bus.btn_pulse) + int'(bus.btn_level);
    end
    check({tag, "_early"}, early, 0);
    check({tag, "_pulse"}, bus.btn_pulse, 1);
    check({tag, "_level"}, bus.btn_level, 1);
  endtask

  task automatic expect_release(input string tag);
    int bad = 0;
    bus.btn = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      tick();
      if (k < LAT) bad += int'(!bus.btn_level);
      bad += int'(bus.btn_pulse);
    end
    check({tag, "_rel_early"}, bad, 0);
    check({tag, "_rel_level"}, bus.btn_level, 0);
    check({tag, "_rel_held"}, bus.btn_held, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    bus.btn = 1'b0;

    // 1. reset values, press latency, async reset while held, press after reset
    repeat (3) tick();
    check("rst_pulse", bus.btn_pulse, 0);
    check("rst_level", bus.btn_level, 0);
    check("rst_held",  bus.btn_held,  0);
    rst_n = 1'b1;
    bus.btn = 1'b1;
    expect_press("press0");
    tick();
    check("press0_width", bus.btn_pulse, 0);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_level", bus.btn_level, 0);
    check("async_rst_pulse", bus.btn_pulse, 0);
    check("async_rst_held",  bus.btn_held,  0);
    tick();
    rst_n = 1'b1;
    expect_press("press_after_rst");
    tick();
    check("press1_width", bus.btn_pulse, 0);
    expect_release("press1");

    // 2. bounce 1,0,1,0 at 2-cycle spacing, then final rise held
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      bus.btn = (i % 2 == 0);
      repeat (2) begin
        tick();
        acc += int'(bus.btn_pulse) + int'(bus.btn_level);
      end
    end
    check("bounce_quiet", acc, 0);
    bus.btn = 1'b1;
    expect_press("bounce");
    tick();
    check("bounce_width", bus.btn_pulse, 0);
    check("bounce_level_kept", bus.btn_level, 1);
    expect_release("bounce");

    // 3. three-cycle glitch is one short of the debounce threshold
    acc = 0;
    bus.btn = 1'b1;
    repeat (3) tick();
    bus.btn = 1'b0;
    repeat (12) begin
      tick();
      acc += int'(bus.btn_pulse) + int'(bus.btn_level);
    end
    check("glitch_quiet", acc, 0);

`ifdef BTN_AUTOREPEAT_EN
    // 4. auto-repeat: pulses at P+20, then every 8 cycles
    bus.btn = 1'b1;
    expect_press("rpt");
    check("rpt_held_at_p", bus.btn_held, 0);
    for (int k = 1; k <= 60; k++) begin
      tick();
      check($sformatf("rpt_pulse_%0d", k), bus.btn_pulse,
            32'((k >= RD) && ((k - RD) % RP == 0)));
      check($sformatf("rpt_held_%0d", k), bus.btn_held, 32'(k >= RD));
    end
    expect_release("rpt");

    // 5. level falls on the same edge the period timer would fire (P+28)
    bus.btn = 1'b1;
    expect_press("expiry");
    for (int k = 1; k <= 38; k++) begin
      if (k == RD + RP - LAT + 1) bus.btn = 1'b0;
      tick();
      check($sformatf("exp_pulse_%0d", k), bus.btn_pulse, 32'(k == RD));
      check($sformatf("exp_held_%0d", k), bus.btn_held,
            32'((k >= RD) && (k < RD + RP)));
      check($sformatf("exp_level_%0d", k), bus.btn_level, 32'(k < RD + RP));
    end
`else
    // 6. without auto-repeat a long hold yields only the press pulse
    bus.btn = 1'b1;
    expect_press("norpt");
    acc = 0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      acc += int'(bus.btn_pulse);
      check($sformatf("norpt_held_%0d", k), bus.btn_held, 0);
    end
    check("norpt_no_repeat", acc, 0);
    check("norpt_level", bus.btn_level, 1);
    expect_release("norpt");
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
